trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Arbitrates trap sources (ebreak, user breakpoint, CPU error codes) and sequences trap entry and exit for the pipelined RISC-V core.
- Owns the single CSR write port, muxing CPU CSR-instruction writes with its own save writes; stalls the CPU writer when they collide.
- Drives the CPU run-enable (clock-gate qualifier) and the PC redirect used to vector into and return from handler code at 0xF000+.

Parameters:
- TRAP_BASE, 32'hF000, handler vector base address.
- VEC_STRIDE, 32'h4, byte spacing between per-cause vectors.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- src_req  in  5  trap requests; bit i = cause i+1 (1 ebreak, 2 user bkpt, 3 div-by-0, 4 mem access err, 5 decode err)
- src_pc  in  32  PC of the trapping instruction (ID stage)
- pdu_run  in  1  debug-unit resume pulse
- mipd_in  in  32  current mipd CSR value (addr 0x100)
- mepc_in  in  32  current mepc CSR value (addr 0x341)
- cpu_csr_wen  in  1  CPU CSR-instruction write request
- cpu_csr_wadd  in  32  CPU CSR write address
- cpu_csr_din  in  32  CPU CSR write data
- cpu_csr_stall  out  1  CPU CSR write held off this cycle
- csr_wen  out  1  CSR file write enable
- csr_wadd  out  32  CSR file write address
- csr_wdata  out  32  CSR file write data
- cpu_run  out  1  CPU clock enable
- pc_redirect  out  1  one-cycle PC load strobe
- pc_target  out  32  PC load value
- in_trap  out  1  handler program executing
- nested_err  out  1  sticky: error request arrived while in HANDLER
- cause_q  out  3  latched cause (0 = none)

Behaviour:
- States: HALT, IDLE, SAVE_CAUSE, SAVE_EPC, SAVE_TVAL, SAVE_MIPD, VECTOR, HANDLER, RETURN.
- Reset: state=HALT; cause_q=0, latched pc=0, nested_err=0. Combinational outputs at reset: cpu_run=0, in_trap=0, pc_redirect=0, csr_wen=0.
- HALT: cpu_run=0. pdu_run -> IDLE next edge.
- IDLE:
  - cpu_run = ~|src_req (combinational kill in the request cycle).
  - On any src_req, select the lowest set bit (fixed priority: ebreak highest, decode error lowest). Latch cause_q=i+1 and src_pc, then go to SAVE_CAUSE.
- SAVE states: cpu_run=0. One CSR write per state, one cycle each:
  - SAVE_CAUSE: 0x342 <- {29'b0, cause_q}
  - SAVE_EPC: 0x341 <- latched pc
  - SAVE_TVAL: 0x343 <- 0 if cause_q=1, else latched pc
  - SAVE_MIPD: 0x100 <- 0
- After SAVE_MIPD: cause 1 or 2 -> HALT (breakpoint stop, no redirect); cause 3–5 -> VECTOR.
- VECTOR: pc_redirect=1 and pc_target = TRAP_BASE + (cause_q-1)*VEC_STRIDE (32-bit wrap). cpu_run=0. Next state HANDLER.
- HANDLER: cpu_run=1, in_trap=1.
  - mipd_in==1 -> RETURN.
  - Any src_req bit 2..4 set -> nested_err<=1; the request is otherwise ignored.
  - Bits 0..1 are ignored.
- RETURN:
  - cpu_run=0, in_trap=1.
  - pc_redirect=1 with pc_target=mepc_in. mepc_in is sampled here, so handler edits to mepc take effect.
  - Same cycle: CSR write 0x100 <- 0. cause_q<=0. Next state IDLE.
- CSR port arbitration:
  - In SAVE_* and RETURN the sequencer owns the port; if cpu_csr_wen=1, cpu_csr_stall=1 and the CPU write is not performed. The CPU holds its request.
  - In all other states the port passes through: csr_wen=cpu_csr_wen, csr_wadd/csr_wdata follow the CPU inputs, cpu_csr_stall=0.
- Latency: request seen in IDLE at edge N → SAVE writes N+1..N+4 → VECTOR redirect in cycle N+5 → handler runs from N+6.
- Outside VECTOR and RETURN, pc_redirect=0 and pc_target=0.
- rst asserted in any state: returns to HALT next edge; no further CSR writes issue.

Test Plan:
- Reset, then pdu_run pulse → HALT→IDLE, cpu_run=1, csr_wen=0.
- src_req=5'b00100, src_pc=0x0000_0040 → writes 0x342=3, 0x341=0x40, 0x343=0x40, 0x100=0 on consecutive cycles; then pc_redirect with pc_target=0xF008; in_trap=1.
- In HANDLER, mepc_in=0x44 and mipd_in goes to 1 → RETURN: pc_redirect with pc_target=0x44, write 0x100=0, then IDLE, cpu_run=1.
- src_req=5'b00011 → cause 1 wins; 0x343 written 0; ends in HALT with no redirect; pdu_run → IDLE.
- CPU writes 0x341 during SAVE_EPC → cpu_csr_stall=1 and the sequencer's data is written. In HANDLER, a CPU write of 0x100=1 passes through the port unchanged.
- src_req bit3 set during HANDLER → nested_err=1 and stays set; the handler continues. rst asserted mid-SAVE_TVAL → HALT next cycle, no SAVE_MIPD write.

Source files
------------

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap arbitration, CSR save sequencing and handler entry/exit control
module trap_sequencer #(
    parameter logic [31:0] TRAP_BASE  = 32'hF000,
    parameter logic [31:0] VEC_STRIDE = 32'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  src_req,
    input  logic [31:0] src_pc,
    input  logic        pdu_run,
    input  logic [31:0] mipd_in,
    input  logic [31:0] mepc_in,
    input  logic        cpu_csr_wen,
    input  logic [31:0] cpu_csr_wadd,
    input  logic [31:0] cpu_csr_din,
    output logic        cpu_csr_stall,
    output logic        csr_wen,
    output logic [31:0] csr_wadd,
    output logic [31:0] csr_wdata,
    output logic        cpu_run,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        in_trap,
    output logic        nested_err,
    output logic [2:0]  cause_q
);

    localparam logic [3:0] S_HALT       = 4'd0;
    localparam logic [3:0] S_IDLE       = 4'd1;
    localparam logic [3:0] S_SAVE_CAUSE = 4'd2;
    localparam logic [3:0] S_SAVE_EPC   = 4'd3;
    localparam logic [3:0] S_SAVE_TVAL  = 4'd4;
    localparam logic [3:0] S_SAVE_MIPD  = 4'd5;
    localparam logic [3:0] S_VECTOR     = 4'd6;
    localparam logic [3:0] S_HANDLER    = 4'd7;
    localparam logic [3:0] S_RETURN     = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [2:0]  cause_d;
    logic [31:0] pc_q, pc_d;
    logic        nested_q, nested_d;
    logic [2:0]  sel_cause;

    // Descending scan so the lowest set bit (highest priority) is assigned last.
    always_comb begin
        sel_cause = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (src_req[i]) begin
                sel_cause = 3'(i + 1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        pc_d     = pc_q;
        nested_d = nested_q;
        case (state_q)
            S_HALT:       if (pdu_run) state_d = S_IDLE;
            S_IDLE: begin
                if (|src_req) begin
                    cause_d = sel_cause;
                    pc_d    = src_pc;
                    state_d = S_SAVE_CAUSE;
                end
            end
            S_SAVE_CAUSE: state_d = S_SAVE_EPC;
            S_SAVE_EPC:   state_d = S_SAVE_TVAL;
            S_SAVE_TVAL:  state_d = S_SAVE_MIPD;
            S_SAVE_MIPD:  state_d = (cause_q <= 3'd2) ? S_HALT : S_VECTOR;
            S_VECTOR:     state_d = S_HANDLER;
            S_HANDLER: begin
                if (|src_req[4:2]) nested_d = 1'b1;
                if (mipd_in == 32'd1) state_d = S_RETURN;
            end
            S_RETURN: begin
                cause_d = 3'd0;
                state_d = S_IDLE;
            end
            default:      state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_HALT;
            cause_q  <= 3'd0;
            pc_q     <= 32'd0;
            nested_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            nested_q <= nested_d;
        end
    end

    assign nested_err = nested_q;

    // Reset masks every strobe so a sequence cut short never emits another write.
    always_comb begin
        cpu_run       = 1'b0;
        in_trap       = 1'b0;
        pc_redirect   = 1'b0;
        pc_target     = 32'd0;
        cpu_csr_stall = 1'b0;
        csr_wen       = cpu_csr_wen;
        csr_wadd      = cpu_csr_wadd;
        csr_wdata     = cpu_csr_din;
        case (state_q)
            S_IDLE:    cpu_run = ~|src_req;
            S_SAVE_CAUSE, S_SAVE_EPC, S_SAVE_TVAL, S_SAVE_MIPD: begin
                cpu_csr_stall = cpu_csr_wen;
                csr_wen       = 1'b1;
                case (state_q)
                    S_SAVE_CAUSE: begin csr_wadd = 32'h342; csr_wdata = {29'b0, cause_q}; end
                    S_SAVE_EPC:   begin csr_wadd = 32'h341; csr_wdata = pc_q; end
                    S_SAVE_TVAL:  begin csr_wadd = 32'h343; csr_wdata = (cause_q == 3'd1) ? 32'd0 : pc_q; end
                    default:      begin csr_wadd = 32'h100; csr_wdata = 32'd0; end
                endcase
            end
            S_VECTOR: begin
                pc_redirect = 1'b1;
                pc_target   = TRAP_BASE + ({29'b0, cause_q} - 32'd1) * VEC_STRIDE;
            end
            S_HANDLER: begin
                cpu_run = 1'b1;
                in_trap = 1'b1;
            end
            S_RETURN: begin
                in_trap       = 1'b1;
                pc_redirect   = 1'b1;
                pc_target     = mepc_in;
                cpu_csr_stall = cpu_csr_wen;
                csr_wen       = 1'b1;
                csr_wadd      = 32'h100;
                csr_wdata     = 32'd0;
            end
            default: ;
        endcase
        if (rst) begin
            cpu_run       = 1'b0;
            in_trap       = 1'b0;
            pc_redirect   = 1'b0;
            pc_target     = 32'd0;
            cpu_csr_stall = 1'b0;
            csr_wen       = 1'b0;
            csr_wadd      = 32'd0;
            csr_wdata     = 32'd0;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed per-cycle vector bench for trap_sequencer
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  src_req;
    logic [31:0] src_pc;
    logic        pdu_run;
    logic [31:0] mipd_in;
    logic [31:0] mepc_in;
    logic        cpu_csr_wen;
    logic [31:0] cpu_csr_wadd;
    logic [31:0] cpu_csr_din;
    logic        cpu_csr_stall;
    logic        csr_wen;
    logic [31:0] csr_wadd;
    logic [31:0] csr_wdata;
    logic        cpu_run;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        in_trap;
    logic        nested_err;
    logic [2:0]  cause_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .clk(clk), .rst(rst), .src_req(src_req), .src_pc(src_pc), .pdu_run(pdu_run),
        .mipd_in(mipd_in), .mepc_in(mepc_in), .cpu_csr_wen(cpu_csr_wen),
        .cpu_csr_wadd(cpu_csr_wadd), .cpu_csr_din(cpu_csr_din), .cpu_csr_stall(cpu_csr_stall),
        .csr_wen(csr_wen), .csr_wadd(csr_wadd), .csr_wdata(csr_wdata), .cpu_run(cpu_run),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .in_trap(in_trap),
        .nested_err(nested_err), .cause_q(cause_q)
    );

    typedef struct {
        logic        rst;
        logic        pdu;
        logic [4:0]  req;
        logic [31:0] pc;
        logic [31:0] mipd;
        logic [31:0] mepc;
        logic        cwen;
        logic [31:0] cwadd;
        logic [31:0] cdin;
        logic        e_run;
        logic        e_wen;
        logic [31:0] e_wadd;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_redir;
        logic [31:0] e_tgt;
        logic        e_trap;
        logic        e_nest;
        logic [2:0]  e_cause;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic p, input logic [4:0] rq, input logic [31:0] pc,
                       input logic [31:0] mipd, input logic [31:0] mepc, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic run, input logic wen, input logic [31:0] wa, input logic [31:0] wd,
                       input logic st, input logic rd, input logic [31:0] tg, input logic tr,
                       input logic ne, input logic [2:0] ca_q);
        vec_t v;
        v.rst = r; v.pdu = p; v.req = rq; v.pc = pc; v.mipd = mipd; v.mepc = mepc;
        v.cwen = cw; v.cwadd = ca; v.cdin = cd;
        v.e_run = run; v.e_wen = wen; v.e_wadd = wa; v.e_wdata = wd; v.e_stall = st;
        v.e_redir = rd; v.e_tgt = tg; v.e_trap = tr; v.e_nest = ne; v.e_cause = ca_q;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=0x%08h expected=0x%08h", name, row, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; src_req = '0; src_pc = '0; pdu_run = 1'b0; mipd_in = '0; mepc_in = '0;
        cpu_csr_wen = 1'b0; cpu_csr_wadd = '0; cpu_csr_din = '0;

        //  rst pdu req       pc     mipd mepc  cw ca     cd        run wen wadd    wdata     st rd tgt      tr ne cause
        add(1, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 0, 0);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 0, 0);
        add(0, 1, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 0, 0);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        1, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 0, 0);
        add(0, 0, 5'b00100, 32'h40,  0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 0, 0);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 1, 32'h342, 32'h3,    0, 0, 32'h0,   0, 0, 3);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     1, 32'h341, 32'hDEAD, 0, 1, 32'h341, 32'h40,   1, 0, 32'h0,   0, 0, 3);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     1, 32'h341, 32'hDEAD, 0, 1, 32'h343, 32'h40,   1, 0, 32'h0,   0, 0, 3);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     1, 32'h341, 32'hDEAD, 0, 1, 32'h100, 32'h0,    1, 0, 32'h0,   0, 0, 3);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     1, 32'h341, 32'hDEAD, 0, 1, 32'h341, 32'hDEAD, 0, 1, 32'hF008, 0, 0, 3);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     1, 32'h100, 32'h1,    1, 1, 32'h100, 32'h1,    0, 0, 32'h0,   1, 0, 3);
        add(0, 0, 5'b01000, 32'h0,   0, 0,     0, 0,     0,        1, 0, 32'h0,   32'h0,    0, 0, 32'h0,   1, 0, 3);
        add(0, 0, 5'b00000, 32'h0,   1, 32'h44, 0, 0,     0,        1, 0, 32'h0,   32'h0,    0, 0, 32'h0,   1, 1, 3);
        add(0, 0, 5'b00000, 32'h0,   1, 32'h44, 0, 0,     0,        0, 1, 32'h100, 32'h0,    0, 1, 32'h44,  1, 1, 3);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        1, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 1, 0);
        add(0, 0, 5'b00011, 32'h80,  0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 1, 0);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 1, 32'h342, 32'h1,    0, 0, 32'h0,   0, 1, 1);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 1, 32'h341, 32'h80,   0, 0, 32'h0,   0, 1, 1);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 1, 32'h343, 32'h0,    0, 0, 32'h0,   0, 1, 1);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 1, 32'h100, 32'h0,    0, 0, 32'h0,   0, 1, 1);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 1, 1);
        add(0, 1, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 1, 1);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        1, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 1, 1);
        add(0, 0, 5'b10000, 32'h100, 0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 1, 1);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 1, 32'h342, 32'h5,    0, 0, 32'h0,   0, 1, 5);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 1, 32'h341, 32'h100,  0, 0, 32'h0,   0, 1, 5);
        add(1, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 1, 5);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 0, 0);
        add(0, 0, 5'b00000, 32'h0,   0, 0,     0, 0,     0,        0, 0, 32'h0,   32'h0,    0, 0, 32'h0,   0, 0, 0);

        for (int r = 0; r < vq.size(); r++) begin
            @(negedge clk);
            rst = vq[r].rst; pdu_run = vq[r].pdu; src_req = vq[r].req; src_pc = vq[r].pc;
            mipd_in = vq[r].mipd; mepc_in = vq[r].mepc; cpu_csr_wen = vq[r].cwen;
            cpu_csr_wadd = vq[r].cwadd; cpu_csr_din = vq[r].cdin;
            #2;
            chk("cpu_run",     r, 32'(cpu_run),       32'(vq[r].e_run));
            chk("csr_wen",     r, 32'(csr_wen),       32'(vq[r].e_wen));
            if (vq[r].e_wen) begin
                chk("csr_wadd",  r, csr_wadd,  vq[r].e_wadd);
                chk("csr_wdata", r, csr_wdata, vq[r].e_wdata);
            end
            chk("cpu_csr_stall", r, 32'(cpu_csr_stall), 32'(vq[r].e_stall));
            chk("pc_redirect", r, 32'(pc_redirect),   32'(vq[r].e_redir));
            chk("pc_target",   r, pc_target,          vq[r].e_tgt);
            chk("in_trap",     r, 32'(in_trap),       32'(vq[r].e_trap));
            chk("nested_err",  r, 32'(nested_err),    32'(vq[r].e_nest));
            chk("cause_q",     r, 32'(cause_q),       32'(vq[r].e_cause));
        end

        // Decode error from HALT: resume, request, then expect the vector redirect exactly four cycles after SAVE_CAUSE.
        begin
            int k;
            logic found;
            @(negedge clk); rst = 1'b0; pdu_run = 1'b1; src_req = '0; cpu_csr_wen = 1'b0;
            @(negedge clk); pdu_run = 1'b0; src_req = 5'b10000; src_pc = 32'h200;
            @(negedge clk); src_req = '0;
            found = 1'b0;
            k = 0;
            while (k < 10) begin
                #2;
                if (pc_redirect) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
                k++;
            end
            chk("vec_found",   100, 32'(found),   32'd1);
            chk("vec_latency", 100, k,            4);
            chk("vec_target",  100, pc_target,    32'hF010);
            chk("vec_cpu_run", 100, 32'(cpu_run), 32'd0);
            @(negedge clk); #2;
            chk("hnd_in_trap", 101, 32'(in_trap), 32'd1);
            chk("hnd_cpu_run", 101, 32'(cpu_run), 32'd1);
            chk("hnd_cause",   101, 32'(cause_q), 32'd5);
            chk("hnd_csr_wen", 101, 32'(csr_wen), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
